// File: rtl/riscv_hpm_counter_bank.sv
// RISC-V hpm counter bank: counters, event selectors and mcountinhibit on the shared CSR port; reads are combinational.
// Writes land at the next edge; event pulses show two edges after they arrive. No backpressure; every access completes in one cycle.
// Define RISCV_HPM_OVERFLOW_IRQ_EN to add per-counter overflow flags, enables (0x7C0/0x7C1) and a registered interrupt.
module riscv_hpm_counter_bank #(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [11:0]           read_address,
  output logic [31:0]           read_data_out,
  output logic                  read_hit_out,
  input  logic [11:0]           write_address,
  input  logic [31:0]           write_data_in,
  input  logic [1:0]            write_mode,
  output logic                  overflow_irq_out
);

  localparam int HW = COUNTER_WIDTH - 32;

  function automatic logic [31:0] apply_op(input logic [1:0] mode, input logic [31:0] old_val,
                                           input logic [31:0] wdat);
    case (mode)
      2'b01:   apply_op = wdat;
      2'b10:   apply_op = old_val | wdat;
      2'b11:   apply_op = old_val & ~wdat;
      default: apply_op = old_val;
    endcase
  endfunction

  logic [NUM_EVENTS-1:0]   event_q;
  logic [NUM_COUNTERS-1:0] inhibit;
  logic [31:0]             ev_ext;
  logic                    wr_en;
  logic [31:0]             inh_word;

  // Bit 0 is a permanent zero so that selector 0 and out-of-range selectors count nothing.
  assign ev_ext   = 32'({event_q, 1'b0});
  assign wr_en    = (write_mode != 2'b00);
  assign inh_word = 32'({inhibit, 3'b000});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q <= '0;
      inhibit <= '0;
    end else begin
      event_q <= event_in;
      if (wr_en && write_address == 12'h320)
        inhibit <= NUM_COUNTERS'(apply_op(write_mode, inh_word, write_data_in) >> 3);
    end
  end

  logic [NUM_COUNTERS-1:0][31:0] rd_dat;
  logic [NUM_COUNTERS-1:0]       rd_hit;
`ifdef RISCV_HPM_OVERFLOW_IRQ_EN
  logic [NUM_COUNTERS-1:0]       wrap;
`endif

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    localparam logic [11:0] LO_ADDR  = 12'hB03 + 12'(g);
    localparam logic [11:0] HI_ADDR  = 12'hB83 + 12'(g);
    localparam logic [11:0] SEL_ADDR = 12'h323 + 12'(g);

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [4:0]               sel_q;
    logic                     wr_lo, wr_hi, inc;

    assign wr_lo = wr_en && (write_address == LO_ADDR);
    assign wr_hi = wr_en && (write_address == HI_ADDR);
    // A write to either half of this counter drops the same-cycle increment.
    assign inc   = ev_ext[sel_q] && !inhibit[g] && !wr_lo && !wr_hi;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        sel_q <= '0;
      end else begin
        if (wr_lo)
          cnt_q <= {cnt_q[COUNTER_WIDTH-1:32], apply_op(write_mode, cnt_q[31:0], write_data_in)};
        else if (wr_hi)
          cnt_q <= {HW'(apply_op(write_mode, 32'(cnt_q[COUNTER_WIDTH-1:32]), write_data_in)),
                    cnt_q[31:0]};
        else if (inc)
          cnt_q <= cnt_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        if (wr_en && write_address == SEL_ADDR)
          sel_q <= 5'(apply_op(write_mode, 32'(sel_q), write_data_in));
      end
    end

`ifdef RISCV_HPM_OVERFLOW_IRQ_EN
    assign wrap[g] = inc && (&cnt_q);
`endif

    assign rd_hit[g] = (read_address == LO_ADDR) || (read_address == HI_ADDR) ||
                       (read_address == SEL_ADDR);
    assign rd_dat[g] = (read_address == LO_ADDR)  ? cnt_q[31:0] :
                       (read_address == HI_ADDR)  ? 32'(cnt_q[COUNTER_WIDTH-1:32]) :
                       (read_address == SEL_ADDR) ? 32'(sel_q) : 32'h0;
  end

`ifdef RISCV_HPM_OVERFLOW_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_flag, ovf_en;
  logic                    irq_q;
  logic                    flag_wr;

  assign flag_wr = wr_en && (write_address == 12'h7C0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag <= '0;
      ovf_en   <= '0;
      irq_q    <= 1'b0;
    end else begin
      // Hardware wrap is ORed last so it beats a same-cycle software clear.
      if (flag_wr && write_mode == 2'b10)
        ovf_flag <= ovf_flag | write_data_in[NUM_COUNTERS-1:0] | wrap;
      else if (flag_wr)
        ovf_flag <= (ovf_flag & ~write_data_in[NUM_COUNTERS-1:0]) | wrap;
      else
        ovf_flag <= ovf_flag | wrap;
      if (wr_en && write_address == 12'h7C1)
        ovf_en <= NUM_COUNTERS'(apply_op(write_mode, 32'(ovf_en), write_data_in));
      irq_q <= |(ovf_flag & ovf_en);
    end
  end

  assign overflow_irq_out = irq_q;
`else
  assign overflow_irq_out = 1'b0;
`endif

  always_comb begin
    read_data_out = 32'h0;
    read_hit_out  = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      read_data_out = read_data_out | rd_dat[i];
      read_hit_out  = read_hit_out | rd_hit[i];
    end
    if (read_address == 12'h320) begin
      read_data_out = inh_word;
      read_hit_out  = 1'b1;
    end
`ifdef RISCV_HPM_OVERFLOW_IRQ_EN
    if (read_address == 12'h7C0) begin
      read_data_out = 32'(ovf_flag);
      read_hit_out  = 1'b1;
    end
    if (read_address == 12'h7C1) begin
      read_data_out = 32'(ovf_en);
      read_hit_out  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_riscv_hpm_counter_bank.sv
// Directed bench for riscv_hpm_counter_bank (default build); expected reads queued on issue, popped on compare.
module tb_riscv_hpm_counter_bank;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  event_in = '0;
  logic [11:0] read_address = '0;
  logic [31:0] read_data_out;
  logic        read_hit_out;
  logic [11:0] write_address = '0;
  logic [31:0] write_data_in = '0;
  logic [1:0]  write_mode = 2'b00;
  logic        overflow_irq_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_dat_q[$];
  logic        exp_hit_q[$];

  riscv_hpm_counter_bank #(.NUM_COUNTERS(4), .NUM_EVENTS(8), .COUNTER_WIDTH(40)) dut (
    .clk(clk), .reset_n(reset_n), .event_in(event_in),
    .read_address(read_address), .read_data_out(read_data_out), .read_hit_out(read_hit_out),
    .write_address(write_address), .write_data_in(write_data_in), .write_mode(write_mode),
    .overflow_irq_out(overflow_irq_out)
  );

  always #5 clk = ~clk;

  // Issue a read, queue its expectation, then compare 1 ns later (well before the next posedge).
  task automatic check_rd(input logic [11:0] addr, input logic [31:0] exp_dat, input logic exp_hit,
                          input string tag);
    logic [31:0] e_dat;
    logic        e_hit;
    exp_dat_q.push_back(exp_dat);
    exp_hit_q.push_back(exp_hit);
    read_address = addr;
    #1;
    e_dat = exp_dat_q.pop_front();
    e_hit = exp_hit_q.pop_front();
    checks++;
    assert (read_data_out === e_dat) else begin
      errors++;
      $error("FAIL %s data got %h want %h", tag, read_data_out, e_dat);
    end
    checks++;
    assert (read_hit_out === e_hit) else begin
      errors++;
      $error("FAIL %s hit got %b want %b", tag, read_hit_out, e_hit);
    end
  endtask

  task automatic check_irq(input logic exp_irq, input string tag);
    checks++;
    assert (overflow_irq_out === exp_irq) else begin
      errors++;
      $error("FAIL %s irq got %b want %b", tag, overflow_irq_out, exp_irq);
    end
  endtask

  // Called just after a negedge: drive for one edge, return at the following negedge.
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] dat, input logic [1:0] mode);
    write_address = addr;
    write_data_in = dat;
    write_mode    = mode;
    @(negedge clk);
    write_mode    = 2'b00;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_rd(12'hB03, 32'h0, 1'b1, "rst_cnt");
    check_irq(1'b0, "rst_irq");
    reset_n = 1'b1;
    @(negedge clk);
    check_rd(12'h323, 32'h0, 1'b1, "rst_sel");
    check_rd(12'h320, 32'h0, 1'b1, "rst_inh");
    check_rd(12'hB02, 32'h0, 1'b0, "unmapped");
    @(negedge clk);

    // Counting on event 0, with first-increment latency check.
    csr_write(12'h323, 32'd1, 2'b01);
    check_rd(12'h323, 32'd1, 1'b1, "sel_wr");
    event_in = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check_rd(12'hB03, 32'd0, 1'b1, "lat_n1");
      if (k == 2) check_rd(12'hB03, 32'd1, 1'b1, "lat_n2");
      if (k == 10) event_in = 8'h00;
    end
    repeat (2) @(negedge clk);
    check_rd(12'hB03, 32'd10, 1'b1, "count10");

    // Inhibit freezes the counter.
    csr_write(12'h320, 32'h8, 2'b01);
    check_rd(12'h320, 32'h8, 1'b1, "inh_rd");
    event_in = 8'h01;
    repeat (5) @(negedge clk);
    event_in = 8'h00;
    repeat (2) @(negedge clk);
    check_rd(12'hB03, 32'd10, 1'b1, "inhibited");
    csr_write(12'h320, 32'h0, 2'b01);

    // Unimplemented high bits, then wrap at 2^40.
    csr_write(12'hB83, 32'hFFFF_FFFF, 2'b01);
    check_rd(12'hB83, 32'h0000_00FF, 1'b1, "hi_mask");
    csr_write(12'hB03, 32'hFFFF_FFFF, 2'b01);
    check_rd(12'hB03, 32'hFFFF_FFFF, 1'b1, "lo_ones");
    event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00;
    repeat (2) @(negedge clk);
    check_rd(12'hB03, 32'h0, 1'b1, "wrap_lo");
    check_rd(12'hB83, 32'h0, 1'b1, "wrap_hi");
    check_rd(12'h7C0, 32'h0, 1'b0, "ovf_unmapped");
    check_irq(1'b0, "irq_off");
    @(negedge clk);

    // Write beats a same-cycle increment; a high-half write also suppresses it.
    event_in = 8'h01;
    repeat (3) @(negedge clk);
    csr_write(12'hB03, 32'd5, 2'b01);
    check_rd(12'hB03, 32'd5, 1'b1, "wr_wins");
    @(negedge clk);
    check_rd(12'hB03, 32'd6, 1'b1, "after_wr");
    csr_write(12'hB83, 32'h0, 2'b01);
    check_rd(12'hB03, 32'd6, 1'b1, "hi_wr_supp");
    event_in = 8'h00;
    @(negedge clk);

    // Set and clear modes on mcountinhibit.
    csr_write(12'h320, 32'h10, 2'b10);
    check_rd(12'h320, 32'h10, 1'b1, "inh_set");
    csr_write(12'h320, 32'h10, 2'b11);
    check_rd(12'h320, 32'h0, 1'b1, "inh_clr");

    // Selector 31 counts nothing; selector 8 picks event_in[7].
    csr_write(12'h323, 32'd31, 2'b01);
    csr_write(12'h324, 32'd8, 2'b01);
    csr_write(12'hB03, 32'd0, 2'b01);
    check_rd(12'h323, 32'd31, 1'b1, "sel31_rd");
    event_in = 8'hFF;
    repeat (3) @(negedge clk);
    event_in = 8'h00;
    repeat (2) @(negedge clk);
    check_rd(12'hB03, 32'd0, 1'b1, "sel31_none");
    check_rd(12'hB04, 32'd3, 1'b1, "sel8_cnt");

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    check_rd(12'hB04, 32'd0, 1'b1, "arst_cnt");
    check_rd(12'h324, 32'd0, 1'b1, "arst_sel");
    check_irq(1'b0, "arst_irq");
    @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
